mul_add_pipe_reg: RTL and testbench



---
 rtl/mul_add_pipe_reg_if.sv | 16 +
 rtl/mul_add_pipe_reg.sv | 136 +++++++++++++
 tb/tb_mul_add_pipe_reg.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_add_pipe_reg_if.sv
// One valid/ready beat of partial products plus the sign/exponent side-band.
// The master drives valid and the payload; the slave drives ready.
interface mul_add_pipe_reg_if #(
   parameter int NUM_PP = 13,
   parameter int PP_W   = 49,
   parameter int EXP_W  = 9
);
   logic                   valid;
   logic                   ready;
   logic [NUM_PP*PP_W-1:0] pp;
   logic                   sign;
   logic [EXP_W-1:0]       expc;

   modport master (output valid, output pp, output sign, output expc, input ready);
   modport slave  (input valid, input pp, input sign, input expc, output ready);
endinterface

// File: rtl/mul_add_pipe_reg.sv
// Registered two-entry skid stage between the partial-product generator and the adder tree.
// Optional macro MUL_ADD_STALL_CNT_EN adds a saturating 16-bit output stall counter.
module mul_add_pipe_reg #(
   parameter int NUM_PP = 13,
   parameter int PP_W   = 49,
   parameter int EXP_W  = 9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   mul_add_pipe_reg_if.slave  in_if,
   mul_add_pipe_reg_if.master out_if
`ifdef MUL_ADD_STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);
   localparam int PP_BITS = NUM_PP * PP_W;
   localparam int PAY_W   = PP_BITS + 1 + EXP_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [PAY_W-1:0] main_q, main_d;
   logic [PAY_W-1:0] skid_q, skid_d;
   logic [PAY_W-1:0] in_pay_s;
   logic             accept_s;
   logic             xfer_s;

   assign in_pay_s = {in_if.pp, in_if.sign, in_if.expc};
   assign accept_s = in_if.valid & in_ready_q;
   assign xfer_s   = out_valid_q & out_if.ready;

   // Next-state and payload routing; flush wins over accept/transfer and leaves payloads untouched.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_s) begin
                  main_d  = in_pay_s;
                  state_d = ST_BUSY;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_BUSY: begin
               if (accept_s && xfer_s) begin
                  main_d  = in_pay_s;
                  state_d = ST_BUSY;
               end else if (accept_s) begin
                  skid_d  = in_pay_s;
                  state_d = ST_FULL;
               end else if (xfer_s) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_BUSY;
               end
            end
            ST_FULL: begin
               if (xfer_s) begin
                  main_d  = skid_q;
                  state_d = ST_BUSY;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // State, handshake flags and payload registers; in_ready stays low until the first edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         main_q      <= {PAY_W{1'b0}};
         skid_q      <= {PAY_W{1'b0}};
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
      end
   end

   assign in_if.ready  = in_ready_q;
   assign out_if.valid = out_valid_q;
   assign out_if.pp    = main_q[PAY_W-1 -: PP_BITS];
   assign out_if.sign  = main_q[EXP_W];
   assign out_if.expc  = main_q[EXP_W-1:0];

`ifdef MUL_ADD_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles a held beat is refused downstream.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         stall_cnt_d = 16'd0;
      end else if (out_valid_q && !out_if.ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mul_add_pipe_reg.sv
// Bench for mul_add_pipe_reg: a queue model of the held beats is checked every cycle,
// directed scenarios pin literal values, and a randomized phase exercises mixed traffic.
module tb_mul_add_pipe_reg;
   localparam int NUM_PP  = 13;
   localparam int PP_W    = 49;
   localparam int EXP_W   = 9;
   localparam int PP_BITS = NUM_PP * PP_W;
   localparam int PAY_W   = PP_BITS + 1 + EXP_W;
   localparam int CW      = 704;

   logic clk;
   logic rst_n;
   logic flush;
   int   n_chk  = 0;
   int   n_fail = 0;

   mul_add_pipe_reg_if #(.NUM_PP(NUM_PP), .PP_W(PP_W), .EXP_W(EXP_W)) in_bus ();
   mul_add_pipe_reg_if #(.NUM_PP(NUM_PP), .PP_W(PP_W), .EXP_W(EXP_W)) out_bus ();

`ifdef MUL_ADD_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   mul_add_pipe_reg #(.NUM_PP(NUM_PP), .PP_W(PP_W), .EXP_W(EXP_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .in_if  (in_bus.slave),
      .out_if (out_bus.master)
`ifdef MUL_ADD_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [PAY_W-1:0] rnd_pay();
      logic [CW-1:0] t;
      for (int k = 0; k < CW / 32; k++) t[k*32 +: 32] = $urandom;
      return t[PAY_W-1:0];
   endfunction

   function automatic logic [PAY_W-1:0] idx_pay(input int i, input logic s);
      logic [PP_BITS-1:0] pp;
      logic [EXP_W-1:0]   e;
      pp = '0;
      pp[PP_W-1:0] = PP_W'(i);
      e = 9'h0FF + EXP_W'(i);
      return {pp, s, e};
   endfunction

   function automatic logic [PAY_W-1:0] out_pay();
      return {out_bus.pp, out_bus.sign, out_bus.expc};
   endfunction

   // Behavioural model: the beats currently held, oldest first (capacity two).
   logic [PAY_W-1:0] mq[$];
   bit               m_first = 1'b1;
   bit               m_acc, m_xfer;
   logic [15:0]      m_cnt = 16'd0;

   function automatic bit exp_ready();
      return !m_first && (mq.size() < 2);
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_first = 1'b1;
            m_cnt   = 16'd0;
         end else if (flush) begin
            mq.delete();
            m_first = 1'b0;
            m_cnt   = 16'd0;
         end else begin
            m_xfer = (mq.size() > 0) && out_bus.ready;
            m_acc  = in_bus.valid && exp_ready();
            if ((mq.size() > 0) && !out_bus.ready && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
            if (m_xfer) void'(mq.pop_front());
            if (m_acc) mq.push_back({in_bus.pp, in_bus.sign, in_bus.expc});
            m_first = 1'b0;
         end
      end
   end

   // Compare process: every falling edge the DUT must match the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", CW'(out_bus.valid), CW'(1'b0));
         check("rst_in_ready", CW'(in_bus.ready), CW'(1'b0));
         check("rst_payload", CW'(out_pay()), CW'(0));
      end else begin
         check("in_ready", CW'(in_bus.ready), CW'(exp_ready()));
         check("out_valid", CW'(out_bus.valid), CW'(mq.size() > 0));
         if (mq.size() > 0) check("payload", CW'(out_pay()), CW'(mq[0]));
      end
`ifdef MUL_ADD_STALL_CNT_EN
      check("stall_cnt", CW'(stall_cnt), CW'(m_cnt));
`endif
   end

   task automatic drive(input logic v, input logic [PAY_W-1:0] p);
      in_bus.valid = v;
      {in_bus.pp, in_bus.sign, in_bus.expc} = p;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      out_bus.ready = 1'b0;
      drive(1'b0, '0);
      #22 rst_n = 1'b1;
      step();
      check("ready_after_release", CW'(in_bus.ready), CW'(1'b1));

      // Streaming: one beat per cycle, latency one.
      out_bus.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, idx_pay(i, i[0]));
         step();
         check("stream_valid", CW'(out_bus.valid), CW'(1'b1));
         check("stream_pp0", CW'(out_bus.pp[PP_W-1:0]), CW'(i));
         check("stream_expc", CW'(out_bus.expc), CW'(9'h0FF + EXP_W'(i)));
         check("stream_ready", CW'(in_bus.ready), CW'(1'b1));
      end
      drive(1'b0, '0);
      step();

      // Back-pressure: A in main, B in skid, then a held stall with ignored pulses.
      out_bus.ready = 1'b0;
      drive(1'b1, idx_pay(10, 1'b1));
      step();
      drive(1'b1, idx_pay(11, 1'b0));
      step();
      check("bp_ready_low", CW'(in_bus.ready), CW'(1'b0));
      check("bp_main_is_a", CW'(out_bus.expc), CW'(9'h109));
      for (int k = 0; k < 10; k++) begin
         drive(k[0], rnd_pay());
         step();
         check("hold_expc", CW'(out_bus.expc), CW'(9'h109));
      end
      drive(1'b0, '0);
      out_bus.ready = 1'b1;
      step();
      check("bp_b_next", CW'(out_bus.expc), CW'(9'h10A));
      step();
      check("bp_drained", CW'(out_bus.valid), CW'(1'b0));

      // Flush in FULL together with an incoming beat.
      out_bus.ready = 1'b0;
      drive(1'b1, rnd_pay());
      step();
      drive(1'b1, rnd_pay());
      step();
      flush = 1'b1;
      drive(1'b1, rnd_pay());
      step();
      flush = 1'b0;
      drive(1'b0, '0);
      check("flush_valid", CW'(out_bus.valid), CW'(1'b0));
      check("flush_ready", CW'(in_bus.ready), CW'(1'b1));
      out_bus.ready = 1'b1;
      repeat (3) step();

      // Randomized traffic with occasional flush.
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 1)), rnd_pay());
         out_bus.ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 31) == 0);
         step();
      end
      flush = 1'b0;
      drive(1'b0, '0);
      out_bus.ready = 1'b1;
      repeat (3) step();

      // Asynchronous reset between edges while a beat is held.
      out_bus.ready = 1'b0;
      drive(1'b1, rnd_pay());
      step();
      drive(1'b0, '0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_valid", CW'(out_bus.valid), CW'(1'b0));
      check("async_pp", CW'(out_bus.pp), CW'(0));
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      out_bus.ready = 1'b1;
      drive(1'b1, idx_pay(7, 1'b1));
      step();
      check("post_rst_expc", CW'(out_bus.expc), CW'(9'h106));
      check("post_rst_sign", CW'(out_bus.sign), CW'(1'b1));
      drive(1'b0, '0);
      step();

`ifdef MUL_ADD_STALL_CNT_EN
      flush = 1'b1;
      step();
      flush = 1'b0;
      out_bus.ready = 1'b0;
      drive(1'b1, rnd_pay());
      step();
      drive(1'b0, '0);
      repeat (5) step();
      check("stall_5", CW'(stall_cnt), CW'(16'd5));
      repeat (70000) @(posedge clk);
      #1;
      check("stall_sat", CW'(stall_cnt), CW'(16'hFFFF));
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("stall_flush", CW'(stall_cnt), CW'(16'd0));
      out_bus.ready = 1'b1;
      step();
`endif

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
